// File: rtl/branch_predictor_pkg.sv
// Shared constants and types for the bimodal/BTB branch predictor.
package branch_predictor_pkg;

    localparam int PC_W            = 32;
    localparam int DEF_INDEX_BITS  = 6;
    localparam int DEF_TAG_BITS    = 8;

    // 2-bit direction counter encodings
    localparam logic [1:0] BP_CNT_SNT = 2'b00;  // strongly not taken
    localparam logic [1:0] BP_CNT_WNT = 2'b01;  // weakly not taken
    localparam logic [1:0] BP_CNT_WT  = 2'b10;  // weakly taken
    localparam logic [1:0] BP_CNT_ST  = 2'b11;  // strongly taken

    // Counter value loaded into every PHT entry on reset
    localparam logic [1:0] BP_CNT_RESET = BP_CNT_WNT;

    // Even parity over a PC-wide word
    function automatic logic pc_parity(input logic [PC_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// 2-bit saturating counter next-state: count up on taken, down on not-taken.
module bp_sat_counter
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cnt_i,
    input  logic       taken_i,
    output logic [1:0] cnt_next_o
);

    // Saturate at strongly-taken / strongly-not-taken
    always_comb begin
        cnt_next_o = cnt_i;
        if (taken_i) begin
            if (cnt_i == BP_CNT_ST) begin
                cnt_next_o = BP_CNT_ST;
            end else begin
                cnt_next_o = cnt_i + 2'd1;
            end
        end else begin
            if (cnt_i == BP_CNT_SNT) begin
                cnt_next_o = BP_CNT_SNT;
            end else begin
                cnt_next_o = cnt_i - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: bimodal PHT plus direct-mapped tagged BTB.
// Prediction is registered one cycle after lookup; same-cycle training to the
// looked-up index is bypassed so the prediction reflects the update.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int TAG_BITS   = DEF_TAG_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_valid,
    input  logic [PC_W-1:0] fetch_pc,
    input  logic            fetch_stall,
    input  logic            branch_flush,
    input  logic            update_en,
    input  logic [PC_W-1:0] update_pc,
    input  logic            taken_or_not_actual,
    input  logic [PC_W-1:0] branch_actual_addr,
    output logic            pred_valid,
    output logic [PC_W-1:0] pred_pc,
    output logic            pre_is_branch_taken,
    output logic [PC_W-1:0] pre_branch_addr
);

    localparam int DEPTH = 1 << INDEX_BITS;
    localparam int TAG_LO = INDEX_BITS + 2;
    localparam int TAG_HI = INDEX_BITS + TAG_BITS + 1;

    // Tables
    logic [1:0]          pht_q        [DEPTH];
    logic                btb_valid_q  [DEPTH];
    logic [TAG_BITS-1:0] btb_tag_q    [DEPTH];
    logic [PC_W-1:0]     btb_target_q [DEPTH];

    // Output registers
    logic            pred_valid_q, pred_valid_d;
    logic [PC_W-1:0] pred_pc_q,    pred_pc_d;
    logic            taken_q,      taken_d;
    logic [PC_W-1:0] addr_q,       addr_d;

    // Index/tag fields
    logic [INDEX_BITS-1:0] lk_idx_s, up_idx_s;
    logic [TAG_BITS-1:0]   lk_tag_s, up_tag_s;

    // Update and lookup datapath
    logic [1:0]          up_cnt_cur_s, up_cnt_next_s;
    logic                same_idx_s;
    logic [1:0]          lk_cnt_s;
    logic                lk_valid_s;
    logic [TAG_BITS-1:0] lk_btag_s;
    logic [PC_W-1:0]     lk_target_s;
    logic                lk_taken_s;
    logic [PC_W-1:0]     lk_addr_s;

    // Bits outside index/tag never participate in training
    logic unused_upd_bits_s;
    assign unused_upd_bits_s = ^{update_pc[1:0], update_pc[PC_W-1:TAG_HI+1]};

    assign lk_idx_s = fetch_pc[INDEX_BITS+1:2];
    assign lk_tag_s = fetch_pc[TAG_HI:TAG_LO];
    assign up_idx_s = update_pc[INDEX_BITS+1:2];
    assign up_tag_s = update_pc[TAG_HI:TAG_LO];
    assign up_cnt_cur_s = pht_q[up_idx_s];

    // One counter instance feeds both the table write and the lookup bypass
    bp_sat_counter u_sat (
        .cnt_i      (up_cnt_cur_s),
        .taken_i    (taken_or_not_actual),
        .cnt_next_o (up_cnt_next_s)
    );

    // Lookup with write-first bypass from a same-cycle update
    always_comb begin
        same_idx_s  = update_en && (up_idx_s == lk_idx_s);
        lk_cnt_s    = pht_q[lk_idx_s];
        lk_valid_s  = btb_valid_q[lk_idx_s];
        lk_btag_s   = btb_tag_q[lk_idx_s];
        lk_target_s = btb_target_q[lk_idx_s];
        if (same_idx_s) begin
            lk_cnt_s = up_cnt_next_s;
            if (taken_or_not_actual) begin
                lk_valid_s  = 1'b1;
                lk_btag_s   = up_tag_s;
                lk_target_s = branch_actual_addr;
            end else begin
                lk_valid_s  = btb_valid_q[lk_idx_s];
            end
        end else begin
            lk_cnt_s = pht_q[lk_idx_s];
        end
        lk_taken_s = lk_valid_s && (lk_btag_s == lk_tag_s) && lk_cnt_s[1];
        lk_addr_s  = lk_taken_s ? lk_target_s : (fetch_pc + 32'd4);
    end

    // Output next-state: flush kills, stall holds, otherwise capture lookup
    always_comb begin
        pred_valid_d = pred_valid_q;
        pred_pc_d    = pred_pc_q;
        taken_d      = taken_q;
        addr_d       = addr_q;
        if (branch_flush) begin
            pred_valid_d = 1'b0;
        end else if (fetch_stall) begin
            pred_valid_d = pred_valid_q;
        end else begin
            pred_valid_d = fetch_valid;
            if (fetch_valid) begin
                pred_pc_d = fetch_pc;
                taken_d   = lk_taken_s;
                addr_d    = lk_addr_s;
            end else begin
                pred_pc_d = pred_pc_q;
            end
        end
    end

    // Prediction output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid_q <= 1'b0;
            pred_pc_q    <= 32'h0000_0000;
            taken_q      <= 1'b0;
            addr_q       <= 32'h0000_0000;
        end else begin
            pred_valid_q <= pred_valid_d;
            pred_pc_q    <= pred_pc_d;
            taken_q      <= taken_d;
            addr_q       <= addr_d;
        end
    end

    // PHT/BTB training; independent of stall and flush
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pht_q[i]        <= BP_CNT_RESET;
                btb_valid_q[i]  <= 1'b0;
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= 32'h0000_0000;
            end
        end else if (update_en) begin
            pht_q[up_idx_s] <= up_cnt_next_s;
            if (taken_or_not_actual) begin
                btb_valid_q[up_idx_s]  <= 1'b1;
                btb_tag_q[up_idx_s]    <= up_tag_s;
                btb_target_q[up_idx_s] <= branch_actual_addr;
            end
        end
    end

    assign pred_valid          = pred_valid_q;
    assign pred_pc             = pred_pc_q;
    assign pre_is_branch_taken = taken_q;
    assign pre_branch_addr     = addr_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios then random
// traffic, compared against a table-level model of predictor behaviour.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        fetch_stall;
    logic        branch_flush;
    logic        update_en;
    logic [31:0] update_pc;
    logic        taken_or_not_actual;
    logic [31:0] branch_actual_addr;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pre_is_branch_taken;
    logic [31:0] pre_branch_addr;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_cnt [64];
    bit          m_bv  [64];
    int          m_tag [64];
    logic [31:0] m_tgt [64];
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_taken;
    logic [31:0] e_addr;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk                 (clk),
        .rst                 (rst),
        .fetch_valid         (fetch_valid),
        .fetch_pc            (fetch_pc),
        .fetch_stall         (fetch_stall),
        .branch_flush        (branch_flush),
        .update_en           (update_en),
        .update_pc           (update_pc),
        .taken_or_not_actual (taken_or_not_actual),
        .branch_actual_addr  (branch_actual_addr),
        .pred_valid          (pred_valid),
        .pred_pc             (pred_pc),
        .pre_is_branch_taken (pre_is_branch_taken),
        .pre_branch_addr     (pre_branch_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_cnt[i] = 1;
            m_bv[i]  = 1'b0;
            m_tag[i] = 0;
            m_tgt[i] = 32'h0;
        end
        e_valid = 1'b0;
        e_pc    = 32'h0;
        e_taken = 1'b0;
        e_addr  = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        chk("rst_valid", {31'd0, pred_valid}, 32'd0);
        chk("rst_pc",    pred_pc, 32'd0);
        chk("rst_taken", {31'd0, pre_is_branch_taken}, 32'd0);
        chk("rst_addr",  pre_branch_addr, 32'd0);
        rst = 1'b0;
    endtask

    // One cycle: drive inputs, advance the model, clock, compare
    task automatic step(input logic fv, input logic [31:0] pc, input logic st,
                        input logic fl, input logic ue, input logic [31:0] upc,
                        input logic tk, input logic [31:0] tgt);
        int ui, li;
        fetch_valid = fv; fetch_pc = pc; fetch_stall = st; branch_flush = fl;
        update_en = ue; update_pc = upc; taken_or_not_actual = tk; branch_actual_addr = tgt;
        // training happens first so a same-cycle lookup sees it
        if (ue) begin
            ui = int'(upc[7:2]);
            if (tk) begin
                m_cnt[ui] = (m_cnt[ui] + 1 > 3) ? 3 : m_cnt[ui] + 1;
                m_bv[ui]  = 1'b1;
                m_tag[ui] = int'(upc[15:8]);
                m_tgt[ui] = tgt;
            end else begin
                m_cnt[ui] = (m_cnt[ui] - 1 < 0) ? 0 : m_cnt[ui] - 1;
            end
        end
        if (fl) begin
            e_valid = 1'b0;
        end else if (!st) begin
            e_valid = fv;
            if (fv) begin
                li = int'(pc[7:2]);
                e_pc    = pc;
                e_taken = m_bv[li] && (m_tag[li] == int'(pc[15:8])) && (m_cnt[li] >= 2);
                e_addr  = e_taken ? m_tgt[li] : pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        chk("valid", {31'd0, pred_valid}, {31'd0, e_valid});
        if (e_valid) begin
            chk("pred_pc", pred_pc, e_pc);
            chk("taken",   {31'd0, pre_is_branch_taken}, {31'd0, e_taken});
            chk("addr",    pre_branch_addr, e_addr);
        end
    endtask

    initial begin
        logic [31:0] rpc, rupc;
        rst = 1'b1;
        fetch_valid = 1'b0; fetch_pc = 32'h0; fetch_stall = 1'b0; branch_flush = 1'b0;
        update_en = 1'b0; update_pc = 32'h0; taken_or_not_actual = 1'b0; branch_actual_addr = 32'h0;
        model_reset();
        do_reset();

        // 1: cold lookup
        step(1'b1, 32'h1C00_0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("t1_valid", {31'd0, pred_valid}, 32'd1);
        chk("t1_addr",  pre_branch_addr, 32'h1C00_0004);

        // 2: train and alias
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1C00_0010, 1'b1, 32'h1C00_0100);
        step(1'b1, 32'h1C00_0010, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("t2_taken", {31'd0, pre_is_branch_taken}, 32'd1);
        chk("t2_addr",  pre_branch_addr, 32'h1C00_0100);
        step(1'b1, 32'h1C00_0410, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("t2_alias_taken", {31'd0, pre_is_branch_taken}, 32'd0);
        chk("t2_alias_addr",  pre_branch_addr, 32'h1C00_0414);

        // 3: saturation up then down
        repeat (2) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1C00_0010, 1'b1, 32'h1C00_0100);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1C00_0010, 1'b0, 32'h0);
        step(1'b1, 32'h1C00_0010, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("t3_still_taken", {31'd0, pre_is_branch_taken}, 32'd1);
        repeat (2) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1C00_0010, 1'b0, 32'h0);
        step(1'b1, 32'h1C00_0010, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("t3_nt_taken", {31'd0, pre_is_branch_taken}, 32'd0);
        chk("t3_nt_addr",  pre_branch_addr, 32'h1C00_0014);

        // 4: same-cycle bypass
        step(1'b1, 32'h1C00_0020, 1'b0, 1'b0, 1'b1, 32'h1C00_0020, 1'b1, 32'h1C00_0200);
        chk("t4_taken", {31'd0, pre_is_branch_taken}, 32'd1);
        chk("t4_addr",  pre_branch_addr, 32'h1C00_0200);

        // 5: stall holds, flush kills
        step(1'b1, 32'h1C00_0020, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (3) begin
            step(1'b1, 32'h1C00_0000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            chk("t5_hold_pc", pred_pc, 32'h1C00_0020);
        end
        step(1'b1, 32'h1C00_0030, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("t5_flush_valid", {31'd0, pred_valid}, 32'd0);

        // 6: reset during live lookup clears outputs and training
        fetch_valid = 1'b1; fetch_pc = 32'h1C00_0020;
        do_reset();
        step(1'b1, 32'h1C00_0020, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("t6_taken", {31'd0, pre_is_branch_taken}, 32'd0);
        chk("t6_addr",  pre_branch_addr, 32'h1C00_0024);

        // Random traffic over a few indices/tags to force hits, aliasing and bypass
        for (int n = 0; n < 600; n++) begin
            rpc  = {16'h1C00, 6'd0, 2'($urandom_range(0, 3)), 3'd0,
                    3'($urandom_range(0, 7)), 2'($urandom)};
            rupc = {16'h1C00, 6'd0, 2'($urandom_range(0, 3)), 3'd0,
                    3'($urandom_range(0, 7)), 2'($urandom)};
            step(1'($urandom_range(0, 3) != 0), rpc,
                 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 1)), rupc, 1'($urandom_range(0, 2) != 0),
                 $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
